// File: rtl/axis_fb_pkg.sv
// -----------------------------------------------------------------------------
// axis_fb_pkg
// Shared constants for the frame buffer and the downstream 8-word sum
// accelerator: default stream width, default frame length and the read-side
// state encoding of the frame buffer.
// -----------------------------------------------------------------------------
package axis_fb_pkg;

   localparam int FB_DATA_W    = 32;
   localparam int FB_FRAME_LEN = 8;

   // Read-side FSM encoding, kept as plain constants for older consumers.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

endpackage : axis_fb_pkg

// File: rtl/axis_fb_fifo_mem.sv
// -----------------------------------------------------------------------------
// axis_fb_fifo_mem
// DEPTH x DATA_W register-array FIFO with first-word-fall-through read.
// rd_data always shows mem[rd_ptr]; a read only advances the pointer.
//
// Ports:
//   ACLK, ARESETN  clock, synchronous active-low reset
//   wr_en, wr_data write request (ignored while full)
//   rd_en          read request (ignored while empty)
//   rd_data        head-of-queue word
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module axis_fb_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   fill;
   logic              wr_ok;
   logic              rd_ok;

   assign full    = (fill == (ADDR_W+1)'(DEPTH));
   assign empty   = (fill == '0);
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and fill alone define
   // which entries are valid, so resetting data would only cost logic.
   always_ff @(posedge ACLK) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so pointer increments wrap naturally.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({wr_ok, rd_ok})
            2'b10:   fill <= fill + (ADDR_W+1)'(1);
            2'b01:   fill <= fill - (ADDR_W+1)'(1);
            default: fill <= fill;
         endcase
      end
   end

endmodule : axis_fb_fifo_mem

// File: rtl/axis_frame_buffer.sv
// -----------------------------------------------------------------------------
// axis_frame_buffer
// Store-and-forward AXI4-Stream buffer. Input words are buffered and released
// downstream only in whole frames of FRAME_LEN words; M_AXIS_TLAST is
// regenerated on the last word of every frame. Input TLAST does not affect
// framing.
//
// Optional feature (macro AXIS_FB_TLAST_CHECK_EN): adds a sticky tlast_err
// output flagging input TLAST that disagrees with the local word count.
//
// Ports:
//   ACLK, ARESETN      clock, synchronous active-low reset
//   S_AXIS_*           input stream (TDATA/TVALID/TREADY/TLAST)
//   M_AXIS_*           output stream (TDATA/TVALID/TREADY/TLAST)
//   frames_avail       number of complete frames currently buffered
//   tlast_err          (optional) sticky input framing error
// -----------------------------------------------------------------------------
module axis_frame_buffer
   import axis_fb_pkg::*;
#(
   parameter int DATA_W    = FB_DATA_W,
   parameter int FRAME_LEN = FB_FRAME_LEN,
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic [DATA_W-1:0] S_AXIS_TDATA,
   input  logic              S_AXIS_TVALID,
   output logic              S_AXIS_TREADY,
   input  logic              S_AXIS_TLAST,
   output logic [DATA_W-1:0] M_AXIS_TDATA,
   output logic              M_AXIS_TVALID,
   input  logic              M_AXIS_TREADY,
   output logic              M_AXIS_TLAST,
   output logic [ADDR_W:0]   frames_avail
`ifdef AXIS_FB_TLAST_CHECK_EN
   ,
   output logic              tlast_err
`endif
);

   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam int FA_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;
   logic [FA_W-1:0]  frames_nxt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             s_hs;
   logic             m_hs;
   logic             in_last;
   logic             frame_done;
   logic             last_rd;

   axis_fb_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .wr_en   (s_hs),
      .wr_data (S_AXIS_TDATA),
      .rd_en   (m_hs),
      .rd_data (M_AXIS_TDATA),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign S_AXIS_TREADY = !fifo_full;
   assign M_AXIS_TVALID = (state == ST_SEND);
   assign M_AXIS_TLAST  = M_AXIS_TVALID && (out_cnt == CNT_LAST);

   assign s_hs       = S_AXIS_TVALID && S_AXIS_TREADY;
   // SEND is only entered with a whole frame buffered; the empty term is a
   // belt-and-braces guard, not part of normal flow control.
   assign m_hs       = M_AXIS_TVALID && M_AXIS_TREADY && !fifo_empty;
   assign in_last    = (in_cnt == CNT_LAST);
   assign frame_done = s_hs && in_last;
   assign last_rd    = m_hs && M_AXIS_TLAST;

   // Next frame count and read state. The IDLE->SEND decision looks at the
   // post-update frame count so the first word is valid the cycle right after
   // its frame completes, and back-to-back frames stream without a bubble.
   // NOTE: every variable gets a default before any branch so this block
   // cannot infer a latch.
   always_comb begin
      frames_nxt = frames_avail;
      state_nxt  = state;
      if (frame_done && !last_rd)      frames_nxt = frames_avail + FA_W'(1);
      else if (!frame_done && last_rd) frames_nxt = frames_avail - FA_W'(1);
      case (state)
         ST_IDLE: if (frames_nxt != '0) state_nxt = ST_SEND;
         ST_SEND: if (last_rd && (frames_nxt == '0)) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state        <= ST_IDLE;
         frames_avail <= '0;
         in_cnt       <= '0;
         out_cnt      <= '0;
      end else begin
         state        <= state_nxt;
         frames_avail <= frames_nxt;
         if (s_hs) in_cnt  <= in_last ? '0 : in_cnt + CNT_W'(1);
         if (m_hs) out_cnt <= M_AXIS_TLAST ? '0 : out_cnt + CNT_W'(1);
      end
   end

`ifdef AXIS_FB_TLAST_CHECK_EN
   // Sticky: input TLAST must be high exactly on the word that closes a frame.
   always_ff @(posedge ACLK) begin
      if (!ARESETN)                               tlast_err <= 1'b0;
      else if (s_hs && (S_AXIS_TLAST != in_last)) tlast_err <= 1'b1;
   end
`else
   logic unused_tlast;
   assign unused_tlast = S_AXIS_TLAST;
`endif

endmodule : axis_frame_buffer

// File: tb/tb_axis_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_buffer
// Directed self-checking bench for axis_frame_buffer (DATA_W=32, FRAME_LEN=8,
// DEPTH=16). Inputs are driven and outputs sampled on the falling clock edge.
// A queue of accepted input words supplies the expected output data; output
// TLAST is expected on every 8th word delivered since reset.
// -----------------------------------------------------------------------------
module tb_axis_frame_buffer;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] S_AXIS_TDATA;
   logic        S_AXIS_TVALID;
   logic        S_AXIS_TREADY;
   logic        S_AXIS_TLAST;
   logic [31:0] M_AXIS_TDATA;
   logic        M_AXIS_TVALID;
   logic        M_AXIS_TREADY;
   logic        M_AXIS_TLAST;
   logic [4:0]  frames_avail;
`ifdef AXIS_FB_TLAST_CHECK_EN
   logic        tlast_err;
`endif

   axis_frame_buffer #(
      .DATA_W    (32),
      .FRAME_LEN (8),
      .DEPTH     (16)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .frames_avail  (frames_avail)
`ifdef AXIS_FB_TLAST_CHECK_EN
      ,
      .tlast_err     (tlast_err)
`endif
   );

   always #5 ACLK = ~ACLK;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];
   int          rcv_cnt   = 0;
   logic        held      = 1'b0;
   logic [31:0] held_data = '0;
   logic        held_last = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle, called at a falling edge with inputs already set.
   // Predicts the handshakes of the coming rising edge and scores outputs.
   task automatic step();
      logic [31:0] e;
      if (held) begin
         check("stall_valid", M_AXIS_TVALID, 1);
         check("stall_data",  M_AXIS_TDATA,  held_data);
         check("stall_last",  M_AXIS_TLAST,  held_last);
      end
      held      = M_AXIS_TVALID && !M_AXIS_TREADY;
      held_data = M_AXIS_TDATA;
      held_last = M_AXIS_TLAST;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
         check("out_expected", (exp_q.size() != 0), 1);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdead_beef;
         check("out_data", M_AXIS_TDATA, e);
         check("out_last", M_AXIS_TLAST, ((rcv_cnt % 8) == 7));
         rcv_cnt++;
      end
      if (S_AXIS_TVALID && S_AXIS_TREADY) exp_q.push_back(S_AXIS_TDATA);
      @(posedge ACLK);
      @(negedge ACLK);
   endtask

   // Offer n consecutive words starting at value first; TLAST on word last_at.
   task automatic feed(input int first, input int n, input int last_at);
      int sent  = 0;
      int guard = 0;
      S_AXIS_TVALID = 1'b1;
      while (sent < n && guard < 20 * n + 20) begin
         S_AXIS_TDATA = first + sent;
         S_AXIS_TLAST = ((sent + 1) == last_at);
         if (S_AXIS_TREADY) sent++;
         step();
         guard++;
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      check("feed_accepted", sent, n);
   endtask

   task automatic drain(input int target, input int bound);
      int guard = 0;
      while (rcv_cnt < target && guard < bound) begin
         step();
         guard++;
      end
      check("drain_count", rcv_cnt, target);
   endtask

   initial begin
      int acc;
      int leak;
      int guard;

      ARESETN       = 1'b0;
      S_AXIS_TDATA  = '0;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      M_AXIS_TREADY = 1'b0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);

      // Reset state
      check("rst_s_tready",     S_AXIS_TREADY, 1);
      check("rst_m_tvalid",     M_AXIS_TVALID, 0);
      check("rst_m_tlast",      M_AXIS_TLAST,  0);
      check("rst_frames_avail", frames_avail,  0);
`ifdef AXIS_FB_TLAST_CHECK_EN
      check("rst_tlast_err",    tlast_err,     0);
`endif
      ARESETN = 1'b1;

      // Steady stream 1..16: output valid the cycle after word 8, no bubble
      M_AXIS_TREADY = 1'b1;
      S_AXIS_TVALID = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         S_AXIS_TDATA = i;
         if (i >= 9) check("steady_no_bubble", M_AXIS_TVALID, 1);
         else        check("steady_wait",      M_AXIS_TVALID, 0);
         step();
         if (i == 8) check("steady_latency", M_AXIS_TVALID, 1);
      end
      S_AXIS_TVALID = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("steady_frame2_valid", M_AXIS_TVALID, 1);
         step();
      end
      check("steady_rcv",    rcv_cnt,       16);
      check("steady_frames", frames_avail,  0);
      check("steady_idle",   M_AXIS_TVALID, 0);

      // Partial frame held back until completed
      feed(101, 5, 0);
      leak = 0;
      repeat (20) begin
         if (M_AXIS_TVALID) leak++;
         step();
      end
      check("partial_no_valid", leak,         0);
      check("partial_frames",   frames_avail, 0);
      feed(106, 3, 0);
      drain(24, 40);
      check("partial_q_empty",  exp_q.size(), 0);

      // Backpressure until full: 20 offered, 16 accepted
      M_AXIS_TREADY = 1'b0;
      acc = 0;
      for (int k = 0; k < 20; k++) begin
         S_AXIS_TVALID = 1'b1;
         S_AXIS_TDATA  = 201 + acc;
         if (S_AXIS_TREADY) acc++;
         step();
      end
      check("full_accepted", acc,           16);
      check("full_s_tready", S_AXIS_TREADY, 0);
      check("full_frames",   frames_avail,  2);
      check("full_m_tvalid", M_AXIS_TVALID, 1);
      M_AXIS_TREADY = 1'b1;
      S_AXIS_TDATA  = 201 + acc;
      check("full_ready_during_read", S_AXIS_TREADY, 0);
      step();
      check("full_ready_after_read",  S_AXIS_TREADY, 1);
      guard = 0;
      while ((acc < 20 || rcv_cnt < 40) && guard < 80) begin
         S_AXIS_TVALID = (acc < 20);
         S_AXIS_TDATA  = 201 + acc;
         if (S_AXIS_TVALID && S_AXIS_TREADY) acc++;
         step();
         guard++;
      end
      S_AXIS_TVALID = 1'b0;
      check("full_tail_accepted", acc,          20);
      check("full_rcv",           rcv_cnt,      40);
      check("full_left_partial",  frames_avail, 0);

      // TREADY toggling every cycle; 4 leftover + 36 new words = 5 frames
      acc   = 0;
      guard = 0;
      while ((acc < 36 || rcv_cnt < 80) && guard < 400) begin
         S_AXIS_TVALID = (acc < 36);
         S_AXIS_TDATA  = 221 + acc;
         M_AXIS_TREADY = guard[0];
         if (S_AXIS_TVALID && S_AXIS_TREADY) acc++;
         step();
         guard++;
      end
      S_AXIS_TVALID = 1'b0;
      M_AXIS_TREADY = 1'b1;
      check("toggle_accepted", acc,          36);
      check("toggle_rcv",      rcv_cnt,      80);
      check("toggle_frames",   frames_avail, 0);
      check("toggle_q_empty",  exp_q.size(), 0);

      // Reset after 3 output words of a frame
      M_AXIS_TREADY = 1'b0;
      feed(301, 8, 0);
      M_AXIS_TREADY = 1'b1;
      repeat (3) step();
      check("midrst_words_out", rcv_cnt, 83);
      M_AXIS_TREADY = 1'b0;
      ARESETN       = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      check("midrst_m_tvalid", M_AXIS_TVALID, 0);
      check("midrst_frames",   frames_avail,  0);
      check("midrst_s_tready", S_AXIS_TREADY, 1);
      ARESETN = 1'b1;
      exp_q.delete();
      rcv_cnt = 0;
      held    = 1'b0;
      M_AXIS_TREADY = 1'b1;
      feed(401, 8, 0);
      drain(8, 40);
      check("midrst_frames_after", frames_avail, 0);
      check("midrst_q_empty",      exp_q.size(), 0);

      // Misplaced input TLAST on word 4: framing unaffected
      feed(501, 3, 0);
`ifdef AXIS_FB_TLAST_CHECK_EN
      check("tlast_err_clear", tlast_err, 0);
`endif
      feed(504, 1, 1);
`ifdef AXIS_FB_TLAST_CHECK_EN
      check("tlast_err_set", tlast_err, 1);
`endif
      feed(505, 4, 0);
      drain(16, 40);
      check("tlast_frames", frames_avail, 0);
`ifdef AXIS_FB_TLAST_CHECK_EN
      check("tlast_err_sticky", tlast_err, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_axis_frame_buffer

// File: doc/axis_frame_buffer.md
Name: axis_frame_buffer

Overview:
Store-and-forward AXI4-Stream buffer that sits directly upstream of the 8-word sum accelerator.
- Accepts a continuous or gappy 32-bit input stream (from the DMA MM2S).
- Releases data only in whole frames of FRAME_LEN words, so downstream sees an unbroken burst.
- Regenerates M_AXIS_TLAST on the final word of each frame.

Parameters:
DATA_W, 32, stream data width.
FRAME_LEN, 8, words per frame; range 2..DEPTH.
DEPTH, 16, FIFO entries; power of 2, at least FRAME_LEN.
ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESETN  in  1  synchronous active-low reset.
S_AXIS_TDATA  in  DATA_W  input data.
S_AXIS_TVALID  in  1  input valid.
S_AXIS_TREADY  out  1  input ready.
S_AXIS_TLAST  in  1  input last; used only by the optional feature.
M_AXIS_TDATA  out  DATA_W  output data.
M_AXIS_TVALID  out  1  output valid.
M_AXIS_TREADY  in  1  output ready.
M_AXIS_TLAST  out  1  high on word FRAME_LEN-1 of each output frame.
frames_avail  out  ADDR_W+1  complete frames currently buffered.

Behaviour:
- Reset (ARESETN=0 at a clock edge): pointers, fill count, in_cnt, out_cnt and frames_avail all go to 0.
  - Outputs after reset: S_AXIS_TREADY=1, M_AXIS_TVALID=0, M_AXIS_TLAST=0, frames_avail=0.
  - Reset mid-frame discards all buffered and partial data; no partial frame is ever emitted.
- Storage: DEPTH x DATA_W register array with first-word-fall-through read. M_AXIS_TDATA = mem[rd_ptr] combinationally.
- Write side:
  - S_AXIS_TREADY = (fill < DEPTH).
  - On S handshake: write mem[wr_ptr], wr_ptr+1 (wraps mod DEPTH), fill+1.
  - in_cnt counts 0..FRAME_LEN-1. When a word is accepted with in_cnt==FRAME_LEN-1, in_cnt returns to 0 and a frame is marked complete.
- Read side, states IDLE and SEND:
  - IDLE: M_AXIS_TVALID=0. Move to SEND when frames_avail>0.
  - SEND: M_AXIS_TVALID=1 and M_AXIS_TLAST=(out_cnt==FRAME_LEN-1).
  - On M handshake: rd_ptr+1 (wraps), fill-1, out_cnt+1.
  - On the handshake with TLAST: out_cnt=0 and frames_avail-1. Go to IDLE if the post-update frames_avail is 0, else stay in SEND.
  - TVALID holds, with TDATA and TLAST stable, while TREADY=0.
- Latency: the first word of a frame is valid on the cycle after the cycle in which its FRAME_LEN-th input word is accepted. Back-to-back frames stream with no bubble.
- Simultaneous events:
  - Frame-complete and last-word-read in the same cycle: frames_avail unchanged.
  - Write and read in the same cycle: fill unchanged.
  - Full (fill==DEPTH): TREADY=0 even if a read occurs that cycle; a write lands the next cycle.
- Empty: IDLE is always entered with fill==0 or only a partial frame buffered, so no underflow is possible.
- Input TLAST never affects framing in the base block.

Optional Feature:
- Macro AXIS_FB_TLAST_CHECK_EN.
- Defined: adds output port tlast_err (1 bit, reset 0). It is sticky and is set on an accepted input word when:
  - S_AXIS_TLAST=1 and in_cnt!=FRAME_LEN-1, or
  - S_AXIS_TLAST=0 and in_cnt==FRAME_LEN-1.
  It clears only on reset. Data flow is unaffected.
- Undefined: tlast_err port absent; S_AXIS_TLAST is unused.

Decomposition:
- Package axis_fb_pkg: read-side state encoding (IDLE/SEND) and default DATA_W/FRAME_LEN constants, shared with the sum accelerator.
- One natural sub-module, axis_fb_fifo_mem: register array, pointers, fill, full/empty flags.
- Frame counting and the read FSM stay in the top.

Test Plan:
- Steady stream: 16 words 1..16 with TVALID=1 and TREADY=1 -> two frames out, data 1..16 in order; TLAST on words 8 and 16; first output TVALID the cycle after word 8 is accepted.
- Partial frame: 5 words in, then idle 20 cycles -> M_AXIS_TVALID stays 0 and frames_avail=0. Add 3 more words -> an 8-word frame is emitted.
- Backpressure/full: M_AXIS_TREADY=0, 20 input words offered -> exactly 16 accepted, S_AXIS_TREADY=0, frames_avail=2. Release TREADY -> 16 words out, then words 17..20 accepted.
- TREADY toggling every cycle during a frame: TDATA and TLAST stay stable while stalled; no loss or duplication; pointers wrap correctly over 5 frames.
- Reset mid-frame: after 3 output words of a frame, pulse ARESETN low for 1 cycle -> TVALID=0, frames_avail=0, TREADY=1. A subsequent fresh frame is emitted intact.
- With AXIS_FB_TLAST_CHECK_EN: input TLAST on word 4 -> tlast_err=1 from the next cycle and stays set; the output frame is still 8 words with TLAST on word 8.
